// File: rtl/wb_write_queue_if.sv
// rtl/wb_write_queue_if.sv - retire-side, register-file and decode-lookup signals of wb_write_queue
interface wb_write_queue_if #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int AW    = 5
);
    logic                       mem_valid;
    logic [AW-1:0]              mem_rd;
    logic [XLEN-1:0]            mem_data;
    logic                       mem_ready;
    logic                       alu_valid;
    logic [AW-1:0]              alu_rd;
    logic [XLEN-1:0]            alu_data;
    logic                       alu_ready;
    logic                       rf_we;
    logic [AW-1:0]              rf_rd;
    logic [XLEN-1:0]            rf_data;
    logic [AW-1:0]              rs1;
    logic [AW-1:0]              rs2;
    logic                       pend1;
    logic                       pend2;
    logic [XLEN-1:0]            fwd1;
    logic [XLEN-1:0]            fwd2;
    logic [$clog2(DEPTH):0]     count;
    logic                       idle;

    modport master (
        input  mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data, rs1, rs2,
        output mem_ready, alu_ready, rf_we, rf_rd, rf_data, pend1, pend2, fwd1, fwd2,
               count, idle
    );

    modport slave (
        output mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data, rs1, rs2,
        input  mem_ready, alu_ready, rf_we, rf_rd, rf_data, pend1, pend2, fwd1, fwd2,
               count, idle
    );
endinterface

// File: rtl/wb_write_queue.sv
// rtl/wb_write_queue.sv - in-order write-back queue feeding one register-file write per cycle
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    wb_write_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]   rd_q   [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];

    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            rf_we_q, rf_we_d;
    logic [AW-1:0]   rf_rd_q, rf_rd_d;
    logic [XLEN-1:0] rf_data_q, rf_data_d;

    logic [CW-1:0]   free;
    logic            mem_ready, alu_ready;
    logic            mem_push, alu_push, pop;
    logic [PW-1:0]   alu_slot;

    // Credit comes only from entries free before this edge; a same-cycle pop does not count.
    always_comb begin
        free      = CW'(DEPTH) - count_q;
        mem_ready = (free != '0);
        alu_ready = (free >= CW'(2)) || ((free == CW'(1)) && !bus.mem_valid);
        mem_push  = bus.mem_valid && mem_ready && (bus.mem_rd != '0);
        alu_push  = bus.alu_valid && alu_ready && (bus.alu_rd != '0);
        pop       = (count_q != '0);
        alu_slot  = mem_push ? tail_q + PW'(1) : tail_q;
        tail_d    = tail_q + PW'(mem_push) + PW'(alu_push);
        head_d    = head_q + PW'(pop);
        count_d   = count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);
        rf_we_d   = pop;
        rf_rd_d   = rf_rd_q;
        rf_data_d = rf_data_q;
        if (pop) begin
            rf_rd_d   = rd_q[head_q];
            rf_data_d = data_q[head_q];
        end
    end

    // Load entry lands first so the ALU entry is the younger of a same-cycle pair.
    always_ff @(posedge clk) begin
        if (mem_push) begin
            rd_q[tail_q]   <= bus.mem_rd;
            data_q[tail_q] <= bus.mem_data;
        end
        if (alu_push) begin
            rd_q[alu_slot]   <= bus.alu_rd;
            data_q[alu_slot] <= bus.alu_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            rf_we_q   <= 1'b0;
            rf_rd_q   <= '0;
            rf_data_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            rf_we_q   <= rf_we_d;
            rf_rd_q   <= rf_rd_d;
            rf_data_q <= rf_data_d;
        end
    end

    // Port is oldest, then queue head to tail; later hits override so the youngest wins.
    function automatic logic [XLEN:0] lookup(input logic [AW-1:0] rs);
        logic            hit;
        logic [XLEN-1:0] val;
        logic [PW-1:0]   idx;
        hit = 1'b0;
        val = '0;
        if (rf_we_q && (rf_rd_q == rs)) begin
            hit = 1'b1;
            val = rf_data_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (rd_q[idx] == rs)) begin
                hit = 1'b1;
                val = data_q[idx];
            end
        end
        if (rs == '0) begin
            hit = 1'b0;
            val = '0;
        end
        return {hit, val};
    endfunction

    assign {bus.pend1, bus.fwd1} = lookup(bus.rs1);
    assign {bus.pend2, bus.fwd2} = lookup(bus.rs2);

    assign bus.mem_ready = mem_ready;
    assign bus.alu_ready = alu_ready;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_rd     = rf_rd_q;
    assign bus.rf_data   = rf_data_q;
    assign bus.count     = count_q;
    assign bus.idle      = (count_q == '0) && !rf_we_q;
endmodule

// File: tb/tb_wb_write_queue.sv
// tb/tb_wb_write_queue.sv - self-checking bench for wb_write_queue
module tb_wb_write_queue;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;
    localparam int AW    = 5;

    logic clk;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    wb_write_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) bus ();

    wb_write_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } ent_t;

    ent_t            mq[$];
    logic            m_we   = 1'b0;
    logic [AW-1:0]   m_rd   = '0;
    logic [XLEN-1:0] m_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_free();
        return DEPTH - mq.size();
    endfunction

    function automatic bit m_mem_ready();
        return m_free() >= 1;
    endfunction

    function automatic bit m_alu_ready();
        return (m_free() >= 2) || (m_free() == 1 && !bus.mem_valid);
    endfunction

    function automatic logic [XLEN:0] m_lookup(input logic [AW-1:0] rs);
        if (rs == 0) return '0;
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].rd == rs) return {1'b1, mq[i].data};
        if (m_we && m_rd == rs) return {1'b1, m_data};
        return '0;
    endfunction

    task automatic m_step();
        bit   mr, ar;
        ent_t e;
        mr = m_mem_ready();
        ar = m_alu_ready();
        if (mq.size() > 0) begin
            e      = mq.pop_front();
            m_we   = 1'b1;
            m_rd   = e.rd;
            m_data = e.data;
        end else begin
            m_we = 1'b0;
        end
        if (bus.mem_valid && mr && bus.mem_rd != 0) mq.push_back('{bus.mem_rd, bus.mem_data});
        if (bus.alu_valid && ar && bus.alu_rd != 0) mq.push_back('{bus.alu_rd, bus.alu_data});
    endtask

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            mq.delete();
            m_we   = 1'b0;
            m_rd   = '0;
            m_data = '0;
        end else begin
            m_step();
        end
    end

    initial forever begin
        @(negedge clk);
        chk("mdl_mem_ready", bus.mem_ready, m_mem_ready());
        chk("mdl_alu_ready", bus.alu_ready, m_alu_ready());
        chk("mdl_rf_we", bus.rf_we, m_we);
        chk("mdl_rf_rd", bus.rf_rd, m_rd);
        chk("mdl_rf_data", bus.rf_data, m_data);
        chk("mdl_count", bus.count, mq.size());
        chk("mdl_idle", bus.idle, mq.size() == 0 && !m_we);
        chk("mdl_pend1_fwd1", {bus.pend1, bus.fwd1}, m_lookup(bus.rs1));
        chk("mdl_pend2_fwd2", {bus.pend2, bus.fwd2}, m_lookup(bus.rs2));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.mem_valid = 1'b0;
        bus.mem_rd    = '0;
        bus.mem_data  = '0;
        bus.alu_valid = 1'b0;
        bus.alu_rd    = '0;
        bus.alu_data  = '0;
    endtask

    task automatic drive(input logic mv, input logic [AW-1:0] mrd, input logic [XLEN-1:0] md,
                         input logic av, input logic [AW-1:0] ard, input logic [XLEN-1:0] ad);
        bus.mem_valid = mv;
        bus.mem_rd    = mrd;
        bus.mem_data  = md;
        bus.alu_valid = av;
        bus.alu_rd    = ard;
        bus.alu_data  = ad;
    endtask

    initial begin
        // Reset held with both sources presenting data.
        drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66);
        bus.rs1 = 5'd4;
        bus.rs2 = 5'd6;
        repeat (3) tick();
        chk("rst_rf_we", bus.rf_we, 1'b0);
        chk("rst_count", bus.count, 0);
        chk("rst_mem_ready", bus.mem_ready, 1'b1);
        chk("rst_alu_ready", bus.alu_ready, 1'b1);
        chk("rst_idle", bus.idle, 1'b1);
        chk("rst_pend1", bus.pend1, 1'b0);
        clear_inputs();
        bus.rs1 = '0;
        bus.rs2 = '0;
        rst = 1'b1;
        tick();

        // Single ALU write.
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h1234);
        tick();
        clear_inputs();
        chk("single_count", bus.count, 1);
        chk("single_no_bypass", bus.rf_we, 1'b0);
        tick();
        chk("single_rf_we", bus.rf_we, 1'b1);
        chk("single_rf_rd", bus.rf_rd, 5);
        chk("single_rf_data", bus.rf_data, 32'h1234);
        tick();
        chk("single_rf_we_drop", bus.rf_we, 1'b0);
        chk("single_rf_rd_hold", bus.rf_rd, 5);

        // Same-cycle load and ALU result to the same register.
        drive(1'b1, 5'd3, 32'hA, 1'b1, 5'd3, 32'hB);
        tick();
        clear_inputs();
        bus.rs1 = 5'd3;
        #1;
        chk("dual_count", bus.count, 2);
        chk("dual_pend1", bus.pend1, 1'b1);
        chk("dual_fwd1", bus.fwd1, 32'hB);
        tick();
        chk("dual_port0_rd", bus.rf_rd, 3);
        chk("dual_port0_data", bus.rf_data, 32'hA);
        chk("dual_fwd1_q", bus.fwd1, 32'hB);
        tick();
        chk("dual_port1_data", bus.rf_data, 32'hB);
        chk("dual_fwd1_port", bus.fwd1, 32'hB);
        tick();
        chk("dual_pend1_clear", bus.pend1, 1'b0);
        chk("dual_fwd1_clear", bus.fwd1, 32'h0);

        // Sustained dual pressure against a one-per-cycle drain.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, AW'((i * 7) % 31 + 1), 32'h1000 + i,
                  1'b1, AW'((i * 11) % 31 + 1), 32'h2000 + i);
            bus.rs1 = AW'((i * 7) % 31 + 1);
            bus.rs2 = (i % 3 == 0) ? 5'd0 : AW'(((i - 1) * 11) % 31 + 1);
            #1;
            if (i == 4) begin
                chk("full_count", bus.count, 3);
                chk("full_mem_ready", bus.mem_ready, 1'b1);
                chk("full_alu_ready", bus.alu_ready, 1'b0);
            end
            tick();
        end
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h9999);
        #1;
        chk("free1_alu_only_ready", bus.alu_ready, 1'b1);
        tick();
        clear_inputs();
        repeat (6) tick();
        chk("drain_idle", bus.idle, 1'b1);

        // Writes to x0 are accepted and dropped.
        drive(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
        bus.rs1 = 5'd0;
        bus.rs2 = 5'd0;
        #1;
        chk("x0_mem_ready", bus.mem_ready, 1'b1);
        chk("x0_alu_ready", bus.alu_ready, 1'b1);
        chk("x0_pend1", bus.pend1, 1'b0);
        tick();
        clear_inputs();
        chk("x0_count", bus.count, 0);
        tick();
        chk("x0_rf_we", bus.rf_we, 1'b0);
        chk("x0_idle", bus.idle, 1'b1);

        // Asynchronous reset with three writes queued.
        drive(1'b1, 5'd7, 32'h77, 1'b1, 5'd8, 32'h88);
        tick();
        drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA);
        tick();
        clear_inputs();
        chk("mid_count", bus.count, 3);
        chk("mid_rf_we", bus.rf_we, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_rf_we", bus.rf_we, 1'b0);
        chk("mid_rst_count", bus.count, 0);
        repeat (2) tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_no_stale", bus.rf_we, 1'b0);
            chk("post_rst_idle", bus.idle, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
